// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RISC-V ID/EX stage: opcodes, the ALU
// control encoding, the immediate-format enum and the pipeline payload types.
package riscv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned ALU_CW   = 3;

  // Major opcodes handled by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU control encoding
  localparam logic [ALU_CW-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_CW-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_CW-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_CW-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_CW-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_CW-1:0] ALU_SLT = 3'd5;
  localparam logic [ALU_CW-1:0] ALU_SLL = 3'd6;
  localparam logic [ALU_CW-1:0] ALU_SRL = 3'd7;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

  typedef struct packed {
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic              result_src;
    logic              branch;
    logic              jump;
    logic [ALU_CW-1:0] alu_ctrl;
  } ctrl_t;

  // ID/EX payload at the default widths
  typedef struct packed {
    logic                valid;
    ctrl_t               ctrl;
    logic [XLEN_DEF-1:0] rd1;
    logic [XLEN_DEF-1:0] rd2;
    logic [XLEN_DEF-1:0] imm;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc_plus4;
    logic [AW_DEF-1:0]   rd;
    logic [AW_DEF-1:0]   rs1;
    logic [AW_DEF-1:0]   rs2;
  } id_ex_t;

  // ALU operation from funct3/funct7[5]; SUB only exists for R-type
  function automatic logic [ALU_CW-1:0] alu_decode(input logic [2:0] f3,
                                                   input logic f7b5,
                                                   input logic is_r);
    logic [ALU_CW-1:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// NREG x XLEN register file with x0 hardwired to zero and write-through bypass.
// Ports: clk_i, rst_ni (async, active-low, clears every entry); we_i/waddr_i/
// wdata_i write port; raddr1_i/raddr2_i read addresses; rdata1_c_o/rdata2_c_o
// combinational read data (bypassed from the write port on an address match).
module regfile_bypass
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_c_o,
  output logic [XLEN-1:0] rdata2_c_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic            wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  // Storage; entry 0 is never written so it stays zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: x0 is zero, a same-cycle write to the read address wins
  always_comb begin
    rdata1_c_o = mem_q[raddr1_i];
    rdata2_c_o = mem_q[raddr2_i];
    if (wr_en && (waddr_i == raddr1_i)) rdata1_c_o = wdata_i;
    if (wr_en && (waddr_i == raddr2_i)) rdata2_c_o = wdata_i;
    if (raddr1_i == '0) rdata1_c_o = '0;
    if (raddr2_i == '0) rdata2_c_o = '0;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// RISC-V decode stage plus ID/EX pipeline register with stall/flush.
// Inputs: clk, rst (async active-low), InstrD/PCD/PCPlus4D from IF/ID,
// RegWriteW/RDW/ResultW writeback port, StallE/FlushE from the hazard unit.
// Outputs: RS1_D/RS2_D (combinational source addresses), registered EX-side
// controls, operands, immediate, PCs, register addresses and ValidE.
module decode_stage_hz
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  parameter  int unsigned ACW  = 3,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [AW-1:0]   RS1_D,
  output logic [AW-1:0]   RS2_D,
  output logic            RegWriteE,
  output logic            ALU_SrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic            JumpE,
  output logic [ACW-1:0]  ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [AW-1:0]   RD_E,
  output logic [AW-1:0]   RS1_E,
  output logic [AW-1:0]   RS2_E,
  output logic            ValidE
);

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
  } ex_t;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  ctrl_t           ctrl_d;
  imm_src_e        imm_src;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;
  ex_t             ex_d;
  ex_t             ex_q;

  assign instr  = InstrD[31:0];
  assign opcode = instr[6:0];
  assign RS1_D  = AW'(instr[19:15]);
  assign RS2_D  = AW'(instr[24:20]);

  // Instruction bits above 31 carry no encoding when XLEN > 32
  if (XLEN > 32) begin : g_wide
    logic unused_hi;
    assign unused_hi = ^InstrD[XLEN-1:32];
  end

  // Main control decode; unknown opcodes leave every control bit low
  always_comb begin
    ctrl_d  = '0;
    imm_src = IMM_I;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_decode(instr[14:12], instr[30], 1'b1);
      end
      OP_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = alu_decode(instr[14:12], instr[30], 1'b0);
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = 1'b1;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        imm_src          = IMM_J;
      end
      default: ;
    endcase
  end

  // Immediate assembly in 32 bits, then sign-extension to XLEN
  always_comb begin
    imm32 = '0;
    case (imm_src)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  regfile_bypass #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_rf (
    .clk_i      (clk),
    .rst_ni     (rst),
    .we_i       (RegWriteW),
    .waddr_i    (RDW),
    .wdata_i    (ResultW),
    .raddr1_i   (RS1_D),
    .raddr2_i   (RS2_D),
    .rdata1_c_o (rd1_c),
    .rdata2_c_o (rd2_c)
  );

  // ID/EX next state: flush beats stall, stall holds, otherwise capture
  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      ex_d.valid    = 1'b1;
      ex_d.ctrl     = ctrl_d;
      ex_d.rd1      = rd1_c;
      ex_d.rd2      = rd2_c;
      ex_d.imm      = imm_ext;
      ex_d.pc       = PCD;
      ex_d.pc_plus4 = PCPlus4D;
      ex_d.rd       = AW'(instr[11:7]);
      ex_d.rs1      = RS1_D;
      ex_d.rs2      = RS2_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign RegWriteE   = ex_q.ctrl.reg_write;
  assign ALU_SrcE    = ex_q.ctrl.alu_src;
  assign MemWriteE   = ex_q.ctrl.mem_write;
  assign ResultSrcE  = ex_q.ctrl.result_src;
  assign BranchE     = ex_q.ctrl.branch;
  assign JumpE       = ex_q.ctrl.jump;
  assign ALUControlE = ACW'(ex_q.ctrl.alu_ctrl);
  assign RD1_E       = ex_q.rd1;
  assign RD2_E       = ex_q.rd2;
  assign Imm_Ext_E   = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign RD_E        = ex_q.rd;
  assign RS1_E       = ex_q.rs1;
  assign RS2_E       = ex_q.rs2;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: a default 32-bit instance and an
// XLEN=64/NREG=16 instance, with hand-computed expectations.
module tb_decode_stage_hz;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [31:0] instr, pcd, pcp4, resw;
  logic        rww, stall, flush;
  logic [4:0]  rdw;
  logic [4:0]  rs1_d, rs2_d, rd_e, rs1_e, rs2_e;
  logic        rwe, alusrce, mwe, rse, bre, jme, vle;
  logic [2:0]  aluce;
  logic [31:0] rd1e, rd2e, imme, pce, pcp4e;

  decode_stage_hz dut (
    .clk(clk), .rst(rst), .InstrD(instr), .PCD(pcd), .PCPlus4D(pcp4),
    .RegWriteW(rww), .RDW(rdw), .ResultW(resw), .StallE(stall), .FlushE(flush),
    .RS1_D(rs1_d), .RS2_D(rs2_d), .RegWriteE(rwe), .ALU_SrcE(alusrce),
    .MemWriteE(mwe), .ResultSrcE(rse), .BranchE(bre), .JumpE(jme),
    .ALUControlE(aluce), .RD1_E(rd1e), .RD2_E(rd2e), .Imm_Ext_E(imme),
    .PCE(pce), .PCPlus4E(pcp4e), .RD_E(rd_e), .RS1_E(rs1_e), .RS2_E(rs2_e),
    .ValidE(vle)
  );

  // 64-bit, 16-register instance
  logic [63:0] i64, pc64, pcp4_64, res64;
  logic        rw64, stall64, flush64;
  logic [3:0]  rd64;
  logic [3:0]  rs1_d64, rs2_d64, rd_e64, rs1_e64, rs2_e64;
  logic        rwe64, alusrce64, mwe64, rse64, bre64, jme64, vle64;
  logic [2:0]  aluce64;
  logic [63:0] rd1e64, rd2e64, imme64, pce64, pcp4e64;

  decode_stage_hz #(.XLEN(64), .NREG(16), .ACW(3)) dut64 (
    .clk(clk), .rst(rst), .InstrD(i64), .PCD(pc64), .PCPlus4D(pcp4_64),
    .RegWriteW(rw64), .RDW(rd64), .ResultW(res64), .StallE(stall64),
    .FlushE(flush64), .RS1_D(rs1_d64), .RS2_D(rs2_d64), .RegWriteE(rwe64),
    .ALU_SrcE(alusrce64), .MemWriteE(mwe64), .ResultSrcE(rse64),
    .BranchE(bre64), .JumpE(jme64), .ALUControlE(aluce64), .RD1_E(rd1e64),
    .RD2_E(rd2e64), .Imm_Ext_E(imme64), .PCE(pce64), .PCPlus4E(pcp4e64),
    .RD_E(rd_e64), .RS1_E(rs1_e64), .RS2_E(rs2_e64), .ValidE(vle64)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge so outputs are sampled away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs on both instances
    rst   = 1'b0;
    instr = $urandom(); pcd = $urandom(); pcp4 = $urandom(); resw = $urandom();
    rww   = 1'($urandom()); rdw = 5'($urandom());
    stall = 1'($urandom()); flush = 1'($urandom());
    i64   = {$urandom(), $urandom()}; pc64 = {$urandom(), $urandom()};
    pcp4_64 = {$urandom(), $urandom()}; res64 = {$urandom(), $urandom()};
    rw64  = 1'($urandom()); rd64 = 4'($urandom());
    stall64 = 1'($urandom()); flush64 = 1'($urandom());
    tick(); tick();
    chk("reset_all_e", {rwe, alusrce, mwe, rse, bre, jme, aluce, rd_e, rs1_e, rs2_e}, 64'd0);
    chk("reset_data", 64'(rd1e | rd2e | imme | pce | pcp4e), 64'd0);
    chk("reset_valid", 64'(vle), 64'd0);
    chk("reset_valid64", 64'(vle64), 64'd0);
    chk("reset_imm64", imme64, 64'd0);

    // Release; addi x6,x5,0 reads x5 which must be zero
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; rww = 1'b0; rdw = '0; resw = '0;
    instr = 32'h0002_8313; pcd = 32'h10; pcp4 = 32'h14;
    i64 = 64'h13; pc64 = '0; pcp4_64 = '0; rw64 = 1'b0; rd64 = '0; res64 = '0;
    stall64 = 1'b0; flush64 = 1'b0;
    tick();
    chk("x5_after_reset", 64'(rd1e), 64'd0);
    chk("x5_rs1e", 64'(rs1_e), 64'd5);
    chk("x5_valid", 64'(vle), 64'd1);

    // addi x1,x0,10
    instr = 32'h00A0_0093; pcd = 32'h14; pcp4 = 32'h18;
    tick();
    chk("addi_regwrite", 64'(rwe), 64'd1);
    chk("addi_alusrc", 64'(alusrce), 64'd1);
    chk("addi_imm", 64'(imme), 64'd10);
    chk("addi_rd", 64'(rd_e), 64'd1);
    chk("addi_valid", 64'(vle), 64'd1);
    chk("addi_aluctl", 64'(aluce), 64'd0);
    chk("addi_pce", 64'(pce), 64'h14);

    // Bypass: write x3 while addi x4,x3,0 reads it
    rww = 1'b1; rdw = 5'd3; resw = 32'hDEAD_BEEF; instr = 32'h0001_8213;
    #1;
    chk("rs1_d_comb", 64'(rs1_d), 64'd3);
    tick();
    chk("bypass_rd1", 64'(rd1e), 64'hDEAD_BEEF);
    chk("bypass_rs1e", 64'(rs1_e), 64'd3);

    // sub x5,x3,x3 from the array
    rww = 1'b0; instr = 32'h4031_82B3;
    tick();
    chk("sub_rd1", 64'(rd1e), 64'hDEAD_BEEF);
    chk("sub_rd2", 64'(rd2e), 64'hDEAD_BEEF);
    chk("sub_aluctl", 64'(aluce), 64'd1);
    chk("sub_alusrc", 64'(alusrce), 64'd0);

    // Write to x0 is ignored, even by the bypass
    rww = 1'b1; rdw = 5'd0; resw = 32'h1234_5678; instr = 32'h00A0_0093;
    tick();
    chk("x0_bypass", 64'(rd1e), 64'd0);

    // lw x9,-4(x3)
    rww = 1'b0; instr = 32'hFFC1_A483;
    tick();
    chk("lw_resultsrc", 64'(rse), 64'd1);
    chk("lw_imm", 64'(imme), 64'hFFFF_FFFC);
    chk("lw_rd", 64'(rd_e), 64'd9);

    // jal x1,8
    instr = 32'h0080_006F;
    tick();
    chk("jal_ctl", 64'({jme, rwe, bre, mwe}), 64'b1100);
    chk("jal_imm", 64'(imme), 64'd8);

    // Unknown opcode: all controls low, still valid
    instr = 32'h0000_007F;
    tick();
    chk("unk_ctl", 64'({rwe, alusrce, mwe, rse, bre, jme, aluce}), 64'd0);
    chk("unk_valid", 64'(vle), 64'd1);

    // Load x1=0x100, x2=0x55
    rww = 1'b1; rdw = 5'd1; resw = 32'h100; instr = 32'h13;
    tick();
    rdw = 5'd2; resw = 32'h55;
    tick();

    // sw x2,8(x1)
    rww = 1'b0; instr = 32'h0020_A423; pcd = 32'h40; pcp4 = 32'h44;
    #1;
    chk("sw_rs2_d", 64'(rs2_d), 64'd2);
    tick();
    chk("sw_memwrite", 64'(mwe), 64'd1);
    chk("sw_imm", 64'(imme), 64'd8);
    chk("sw_rd1", 64'(rd1e), 64'h100);
    chk("sw_rd2", 64'(rd2e), 64'h55);

    // Stall 3 cycles with changing inputs and a write to x1
    stall = 1'b1; rww = 1'b1; rdw = 5'd1; resw = 32'h999;
    for (int i = 0; i < 3; i++) begin
      instr = (i == 0) ? 32'h00A0_0093 : (i == 1) ? 32'h4031_82B3 : 32'h0080_006F;
      pcd = 32'h80 + 32'(i * 4);
      tick();
      chk("stall_memwrite", 64'(mwe), 64'd1);
      chk("stall_rd1", 64'(rd1e), 64'h100);
      chk("stall_imm_pc", {imme, pce}, {32'd8, 32'h40});
      chk("stall_regwrite", 64'(rwe), 64'd0);
    end

    // Flush and stall together; x7 write still lands
    flush = 1'b1; stall = 1'b1; rww = 1'b1; rdw = 5'd7; resw = 32'h77;
    instr = 32'h0020_A423;
    tick();
    chk("flush_ctl", 64'({rwe, mwe, bre, jme}), 64'd0);
    chk("flush_valid", 64'(vle), 64'd0);
    chk("flush_rd", 64'(rd_e), 64'd0);
    chk("flush_rd1", 64'(rd1e), 64'd0);

    // addi x8,x7,0 shows x7 was written
    flush = 1'b0; stall = 1'b0; rww = 1'b0; instr = 32'h0003_8413;
    tick();
    chk("x7_written", 64'(rd1e), 64'h77);
    chk("x7_valid", 64'(vle), 64'd1);

    // x1 updated during the stall
    instr = 32'h0020_A423;
    tick();
    chk("x1_stall_write", 64'(rd1e), 64'h999);

    // Mid-operation reset aborts capture
    rww = 1'b1; rdw = 5'd10; resw = 32'hAB; instr = 32'h13;
    rst = 1'b0;
    tick();
    chk("midreset_valid", 64'(vle), 64'd0);
    rst = 1'b1; rww = 1'b0; instr = 32'h0005_0013;
    tick();
    chk("midreset_x10", 64'(rd1e), 64'd0);

    // 64-bit build: beq x17,x2,-4 with 16 registers
    i64 = 64'h0000_0000_FE28_8EE3; pc64 = 64'h1000; pcp4_64 = 64'h1004;
    #1;
    chk("w64_rs1_d", 64'(rs1_d64), 64'd1);
    tick();
    chk("w64_imm", imme64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w64_rs1e", 64'(rs1_e64), 64'd1);
    chk("w64_rs2e", 64'(rs2_e64), 64'd2);
    chk("w64_branch", 64'({bre64, aluce64, vle64}), 64'b1_001_1);
    chk("w64_pce", pce64, 64'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
